intr_ctrl_multi: RTL and testbench
==================================

# intr_ctrl_multi

Parametrised interrupt, reset and hypervisor-trap arbiter for the 65CE02-family core, a successor to the single-IRQ interrupt controller. Samples NUM_IRQ level-sensitive IRQ lines, one edge-triggered NMI and a hypervisor trap request. Arbitrates them at instruction boundaries (mc_sync on phi2). Drives the core's interrupt-injection, PC-hold, hypervisor-mode and vector outputs.

## Interface
- NUM_IRQ, 4: IRQ channel count, 1..16; channel 0 is highest priority.
- HYP_VEC_HI, 8'hFF: high byte of the hypervisor trap vector; low byte is 8'h00.
- ID_W, max(1, clog2(NUM_IRQ)): width of the acknowledge ID. Derived; not overridden.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- phi2  in  1  clock enable; all state updates occur only on clk edges with phi2=1.
- mc_sync  in  1  microcode instruction-boundary strobe.
- irq  in  NUM_IRQ  level IRQ requests, active-high.
- irq_en  in  NUM_IRQ  per-channel enable.
- nmi  in  1  NMI request, rising-edge sensitive.
- hyp  in  1  hypervisor trap request, level.
- i_flag  in  1  processor I flag; 1 masks IRQs.
- hyper_rti  in  1  the core is executing RTI out of hypervisor mode.
- intg  out  1  an interrupt sequence is in progress.
- nmig  out  1  the current sequence is an NMI.
- hyperg  out  1  the current sequence is a hypervisor trap.
- resp  out  1  a reset sequence is in progress.
- hyper_mode  out  1  the core is in hypervisor mode.
- pc_hold  out  1  suppress the PC increment during the injected BRK.
- vector_hi / vector_lo  out  8 / 8  current vector address.
- irq_ack  out  1  one-phi2-cycle pulse when an IRQ is taken.
- irq_ack_id  out  ID_W  index of the channel taken; held until the next take.

## Operation
- States: RST, IDLE, TAKEN.
- Reset (reset=0), all asynchronous:
  - state=RST, resp=1, pc_hold=1.
  - intg=nmig=hyperg=0, hyper_mode=0, nmi_pend=0, irq_ack=0, irq_ack_id=0.
  - vector={FF,FC}.
- RST: on the first phi2&mc_sync after reset release, go to IDLE. resp and pc_hold fall on that edge.
- IDLE: on phi2&mc_sync, select the highest-priority source and go to TAKEN; otherwise stay in IDLE. Priority order:
  - hyp, if hyper_mode=0. Sets hyperg=1 and hyper_mode=1. Vector {HYP_VEC_HI,00}.
  - nmi_pend, if hyper_mode=0. Sets nmig=1 and clears nmi_pend. Vector {FF,FA}.
  - Lowest index k with irq[k]&irq_en[k], if i_flag=0 and hyper_mode=0. Pulses irq_ack and sets irq_ack_id=k. Vector per Configuration.
- Every take also sets intg=1 and pc_hold=1.
- TAKEN: the outputs are held. On the next phi2&mc_sync (the end of the injected sequence), intg, nmig, hyperg and pc_hold clear and the state returns to IDLE. Arbitration is not repeated on that same edge; the earliest next take is at the following mc_sync.
- NMI edge detect: nmi is registered on phi2 cycles. nmi_pend sets when prev=0 and nmi=1.
  - If a new edge arrives on the same edge as an NMI take, nmi_pend remains 1.
  - A pending NMI is held through hyper_mode and taken after exit.
- IRQs are level-sensitive with no latching. A request deasserted before mc_sync is lost.
- hyper_mode clears on phi2&hyper_rti. If hyper_rti and a hyp take coincide, the take wins (hyper_mode stays 1).
- An asserted reset mid-sequence aborts immediately to RST. hyper_mode is lost.

## Timing
- Decision latency: outputs change on the same clk edge as the qualifying phi2&mc_sync, so they are visible from the next cycle.
- Asserted IRQ to intg: at most one instruction plus one clock.
- NMI: an edge must be seen on a phi2 cycle. Minimum pulse is one phi2 period.
- irq_ack is exactly one clk wide.
- vector_* are stable for the whole TAKEN state.

## Configuration
- INTR_VECTORED_EN defined:
  - IRQ channel k uses vector {FF, 8'hE0 - 2k}, i.e. FFE0, FFDE, and so on.
  - NUM_IRQ is limited to 16, which keeps the vectors at or above FFC2.
- Undefined:
  - All IRQ channels share {FF,FE}.
  - irq_ack_id is still reported.

## Structure
- Shared package/include (65ce02_inc.vh):
  - State encodings kIC_RST/kIC_IDLE/kIC_TAKEN.
  - Vector constants kVEC_RST=FFFC, kVEC_NMI=FFFA, kVEC_IRQ=FFFE, kVEC_IRQ_BASE_LO=E0.
- One sub-module: intr_prio_enc. A parametrised lowest-index priority encoder giving `valid` plus `id` over NUM_IRQ bits.

## Test plan
- Reset release, mc_sync pulse at cycle 5 → resp=1 with vector FFFC until then; resp=0 and IDLE from cycle 6.
- irq=4'b1010, irq_en=4'b1111, i_flag=0, mc_sync → intg=1, irq_ack pulse, irq_ack_id=1. Vector FFDE with the macro, FFFE without.
- nmi edge plus irq[0] plus hyp all at one mc_sync → hyperg=1, hyper_mode=1, vector FF00. After hyper_rti and the next sync, the NMI is taken with vector FFFA.
- NMI edge on the same edge as an NMI take → a second NMI is taken at the following IDLE mc_sync.
- i_flag=1, irq[2]=1 → no take. i_flag drops → taken with id=2 at the next mc_sync.
- reset asserted during TAKEN with hyper_mode=1 → immediately resp=1, intg=0, hyper_mode=0.

Source files
------------

// File: rtl/intr_ctrl_multi_pkg.sv
// Shared encodings for the 65CE02 multi-source interrupt controller:
// FSM states, fixed vectors and the vectored IRQ address helper.
package intr_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    kIC_RST   = 2'd0,
    kIC_IDLE  = 2'd1,
    kIC_TAKEN = 2'd2
  } ic_state_e;

  localparam logic [15:0] kVEC_RST = 16'hFFFC;
  localparam logic [15:0] kVEC_NMI = 16'hFFFA;
  localparam logic [15:0] kVEC_IRQ = 16'hFFFE;
  localparam logic [7:0]  kVEC_IRQ_BASE_LO = 8'hE0;

  // Channel k lands at E0 - 2k; with at most 16 channels the lowest is C2.
  function automatic logic [7:0] irq_vec_lo(input logic [3:0] id);
    return kVEC_IRQ_BASE_LO - {3'b000, id, 1'b0};
  endfunction

endpackage

// File: rtl/intr_ctrl_multi_prio_enc.sv
// Lowest-index priority encoder: valid when any request bit is set, id is
// the index of the lowest set bit.
module intr_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    // Scan downward so the lowest set index is written last and wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        valid = 1'b1;
        id    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_multi.sv
// Interrupt / reset / hypervisor-trap arbiter for the 65CE02 core.
// Optional INTR_VECTORED_EN gives each IRQ channel its own vector.
module intr_ctrl_multi
  import intr_ctrl_multi_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter logic [7:0]  HYP_VEC_HI = 8'hFF,
  parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phi2,
  input  logic               mc_sync,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               nmi,
  input  logic               hyp,
  input  logic               i_flag,
  input  logic               hyper_rti,
  output logic               intg,
  output logic               nmig,
  output logic               hyperg,
  output logic               resp,
  output logic               hyper_mode,
  output logic               pc_hold,
  output logic [7:0]         vector_hi,
  output logic [7:0]         vector_lo,
  output logic               irq_ack,
  output logic [ID_W-1:0]    irq_ack_id,
  output logic [1:0]         state_dbg
);

  ic_state_e       state, state_nx;
  logic            nmi_prev, nmi_pend, nmi_edge;
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [15:0]     irq_vec;
  logic            take_hyp, take_nmi, take_irq, end_seq, leave_rst;

  intr_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_prio (
    .req   (irq & irq_en),
    .valid (irq_valid),
    .id    (irq_id)
  );

`ifdef INTR_VECTORED_EN
  assign irq_vec = {8'hFF, irq_vec_lo(4'(irq_id))};
`else
  assign irq_vec = kVEC_IRQ;
`endif

  assign nmi_edge  = phi2 & nmi & ~nmi_prev;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= kIC_RST;
    else        state <= state_nx;
  end

  // Arbitration happens only in IDLE; the TAKEN exit edge never re-arbitrates.
  always_comb begin
    state_nx  = state;
    take_hyp  = 1'b0;
    take_nmi  = 1'b0;
    take_irq  = 1'b0;
    end_seq   = 1'b0;
    leave_rst = 1'b0;
    if (phi2 && mc_sync) begin
      case (state)
        kIC_RST: begin
          leave_rst = 1'b1;
          state_nx  = kIC_IDLE;
        end
        kIC_IDLE: begin
          if (!hyper_mode) begin
            if (hyp)                       take_hyp = 1'b1;
            else if (nmi_pend)             take_nmi = 1'b1;
            else if (irq_valid && !i_flag) take_irq = 1'b1;
          end
          if (take_hyp || take_nmi || take_irq) state_nx = kIC_TAKEN;
        end
        kIC_TAKEN: begin
          end_seq  = 1'b1;
          state_nx = kIC_IDLE;
        end
        default: state_nx = kIC_RST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp       <= 1'b1;
      pc_hold    <= 1'b1;
      intg       <= 1'b0;
      nmig       <= 1'b0;
      hyperg     <= 1'b0;
      hyper_mode <= 1'b0;
      nmi_prev   <= 1'b0;
      nmi_pend   <= 1'b0;
      irq_ack    <= 1'b0;
      irq_ack_id <= '0;
      vector_hi  <= kVEC_RST[15:8];
      vector_lo  <= kVEC_RST[7:0];
    end else begin
      // irq_ack is a strict one-clk pulse, independent of phi2.
      irq_ack <= take_irq;
      if (phi2) nmi_prev <= nmi;
      // A fresh edge coinciding with an NMI take keeps the pending flag set.
      nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
      if (take_hyp)                hyper_mode <= 1'b1;
      else if (phi2 && hyper_rti)  hyper_mode <= 1'b0;
      if (leave_rst) begin
        resp    <= 1'b0;
        pc_hold <= 1'b0;
      end
      if (end_seq) begin
        intg    <= 1'b0;
        nmig    <= 1'b0;
        hyperg  <= 1'b0;
        pc_hold <= 1'b0;
      end
      if (take_hyp || take_nmi || take_irq) begin
        intg    <= 1'b1;
        pc_hold <= 1'b1;
      end
      if (take_hyp) begin
        hyperg    <= 1'b1;
        vector_hi <= HYP_VEC_HI;
        vector_lo <= 8'h00;
      end
      if (take_nmi) begin
        nmig      <= 1'b1;
        vector_hi <= kVEC_NMI[15:8];
        vector_lo <= kVEC_NMI[7:0];
      end
      if (take_irq) begin
        irq_ack_id <= irq_id;
        vector_hi  <= irq_vec[15:8];
        vector_lo  <= irq_vec[7:0];
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl_multi.sv
// Directed table-driven bench for intr_ctrl_multi (NUM_IRQ=4), with
// hand-written sequences for reset-state and mid-sequence reset.
module tb_intr_ctrl_multi;

  localparam logic [1:0] ST_RST = 2'd0, ST_IDLE = 2'd1, ST_TAKEN = 2'd2;

  logic       clk = 1'b0;
  logic       reset, phi2, mc_sync, nmi, hyp, i_flag, hyper_rti;
  logic [3:0] irq, irq_en;
  logic       intg, nmig, hyperg, resp, hyper_mode, pc_hold, irq_ack;
  logic [7:0] vector_hi, vector_lo;
  logic [1:0] irq_ack_id, state_dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intr_ctrl_multi dut (
    .clk(clk), .reset(reset), .phi2(phi2), .mc_sync(mc_sync),
    .irq(irq), .irq_en(irq_en), .nmi(nmi), .hyp(hyp), .i_flag(i_flag),
    .hyper_rti(hyper_rti), .intg(intg), .nmig(nmig), .hyperg(hyperg),
    .resp(resp), .hyper_mode(hyper_mode), .pc_hold(pc_hold),
    .vector_hi(vector_hi), .vector_lo(vector_lo), .irq_ack(irq_ack),
    .irq_ack_id(irq_ack_id), .state_dbg(state_dbg)
  );

  // {intg,nmig,hyperg,resp,hyper_mode,pc_hold,vector,irq_ack,id,state}
  typedef logic [26:0] obs_t;

  typedef struct packed {
    logic       p, ms;
    logic [3:0] irq, en;
    logic       nmi, hyp, ifl, rti;
    logic       intg, nmig, hyperg, resp, hm, pch;
    logic [15:0] vec;
    logic       ack;
    logic [1:0] id;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[36];

  function automatic logic [15:0] irq_vec(input int k);
`ifdef INTR_VECTORED_EN
    return {8'hFF, 8'hE0 - 8'(2 * k)};
`else
    return 16'hFFFE;
`endif
  endfunction

  function automatic obs_t observe();
    return {intg, nmig, hyperg, resp, hyper_mode, pc_hold,
            vector_hi, vector_lo, irq_ack, irq_ack_id, state_dbg};
  endfunction

  function automatic obs_t expect_of(input vec_t v);
    return {v.intg, v.nmig, v.hyperg, v.resp, v.hm, v.pch,
            v.vec, v.ack, v.id, v.st};
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    phi2 = v.p; mc_sync = v.ms; irq = v.irq; irq_en = v.en;
    nmi = v.nmi; hyp = v.hyp; i_flag = v.ifl; hyper_rti = v.rti;
  endtask

  task automatic fill_table();
    logic [15:0] v1, v2, v3;
    v1 = irq_vec(1); v2 = irq_vec(2); v3 = irq_vec(3);
    //            p  ms irq   en    nmi hyp ifl rti  intg nmig hypg resp hm pch vec       ack id st
    tbl[0]  = '{1'b0,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'hFFFC,1'b0,2'd0,ST_RST};
    for (int i = 1; i < 5; i++)
      tbl[i] = '{1'b1,1'b0,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'hFFFC,1'b0,2'd0,ST_RST};
    tbl[5]  = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFC,1'b0,2'd0,ST_IDLE};
    tbl[6]  = '{1'b1,1'b1,4'hA,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,v1,      1'b1,2'd1,ST_TAKEN};
    tbl[7]  = '{1'b1,1'b0,4'hA,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,v1,      1'b0,2'd1,ST_TAKEN};
    tbl[8]  = '{1'b1,1'b1,4'hA,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v1,      1'b0,2'd1,ST_IDLE};
    tbl[9]  = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v1,      1'b0,2'd1,ST_IDLE};
    tbl[10] = '{1'b1,1'b1,4'h4,4'hF,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v1,      1'b0,2'd1,ST_IDLE};
    tbl[11] = '{1'b1,1'b1,4'h4,4'hF,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v1,      1'b0,2'd1,ST_IDLE};
    tbl[12] = '{1'b1,1'b1,4'h4,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,v2,      1'b1,2'd2,ST_TAKEN};
    tbl[13] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v2,      1'b0,2'd2,ST_IDLE};
    tbl[14] = '{1'b1,1'b1,4'h1,4'hE,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v2,      1'b0,2'd2,ST_IDLE};
    tbl[15] = '{1'b1,1'b0,4'h1,4'hF,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v2,      1'b0,2'd2,ST_IDLE};
    tbl[16] = '{1'b1,1'b1,4'h1,4'hF,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,16'hFF00,1'b0,2'd2,ST_TAKEN};
    tbl[17] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'hFF00,1'b0,2'd2,ST_IDLE};
    tbl[18] = '{1'b1,1'b1,4'h1,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'hFF00,1'b0,2'd2,ST_IDLE};
    tbl[19] = '{1'b1,1'b0,4'h1,4'hF,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFF00,1'b0,2'd2,ST_IDLE};
    tbl[20] = '{1'b1,1'b1,4'h1,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,16'hFFFA,1'b0,2'd2,ST_TAKEN};
    tbl[21] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[22] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[23] = '{1'b1,1'b0,4'h0,4'hF,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[24] = '{1'b1,1'b0,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[25] = '{1'b1,1'b1,4'h0,4'hF,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,16'hFFFA,1'b0,2'd2,ST_TAKEN};
    tbl[26] = '{1'b1,1'b1,4'h0,4'hF,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[27] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,16'hFFFA,1'b0,2'd2,ST_TAKEN};
    tbl[28] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[29] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[30] = '{1'b1,1'b0,4'h8,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[31] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFA,1'b0,2'd2,ST_IDLE};
    tbl[32] = '{1'b1,1'b1,4'h8,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,v3,      1'b1,2'd3,ST_TAKEN};
    tbl[33] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,v3,      1'b0,2'd3,ST_IDLE};
    tbl[34] = '{1'b1,1'b1,4'h0,4'hF,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,16'hFF00,1'b0,2'd3,ST_TAKEN};
    tbl[35] = '{1'b1,1'b0,4'h0,4'hF,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,16'hFF00,1'b0,2'd3,ST_TAKEN};
  endtask

  localparam obs_t RST_OBS = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,16'hFFFC,1'b0,2'd0,ST_RST};

  initial begin
    reset = 1'b0; phi2 = 1'b1; mc_sync = 1'b0; irq = '0; irq_en = 4'hF;
    nmi = 1'b0; hyp = 1'b0; i_flag = 1'b0; hyper_rti = 1'b0;
    fill_table();

    repeat (3) @(posedge clk);
    #1 check("reset_state", RST_OBS);
    reset = 1'b1;

    for (int i = 0; i < 36; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1 check($sformatf("row%0d", i), expect_of(tbl[i]));
    end

    // Asynchronous reset while TAKEN in hypervisor mode: no clock edge needed.
    #2 reset = 1'b0;
    #1 check("async_reset_mid_taken", RST_OBS);
    @(posedge clk);
    #1 check("reset_held", RST_OBS);
    reset = 1'b1; mc_sync = 1'b1; phi2 = 1'b1; hyp = 1'b0; hyper_rti = 1'b0;
    @(posedge clk);
    #1 check("post_reset_idle",
             {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFC,1'b0,2'd0,ST_IDLE});
    mc_sync = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
